// File: rtl/sar_ctrl_10b.sv
// ----------------------------------------------------------------------------
// sar_ctrl_10b
//   Successive-approximation controller for the 10-bit ADC. Runs the sample
//   phase, then resolves one bit per comparison, MSB first, driving the trial
//   code to the comparator and returning the final code with a one-cycle eoc.
//
// Ports
//   clk          system clock, rising edge
//   rst          asynchronous reset, active low
//   start        conversion request, honoured only in IDLE
//   abort        synchronous abort back to IDLE, no eoc
//   comp_result  comparator decision, 1 keeps the trial bit
//   comp_valid   comp_result valid this cycle
//   comp_req     one-cycle pulse launching a comparison
//   dac_code     trial code to the comparator (0 in IDLE)
//   sample_en    track/sample phase active
//   busy         high in every state except IDLE
//   dout         last completed conversion result
//   eoc          one-cycle pulse, coincident with the cycle dout is new
//   err          sticky timeout flag for the most recent conversion
//
// State table
//   state    | meaning
//   S_IDLE   | waiting for start, dac_code parked at 0
//   S_SAMPLE | sample_en high for SAMPLE_CYCLES cycles
//   S_REQ    | comp_req pulse for current bit k
//   S_WAIT   | waiting for comp_valid or timeout, then resolve bit k
//   S_DONE   | eoc pulse, dout already holds the result
// ----------------------------------------------------------------------------
module sar_ctrl_10b #(
   parameter int N             = 10,
   parameter int SAMPLE_CYCLES = 4,
   parameter int TIMEOUT       = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         start,
   input  logic         abort,
   input  logic         comp_result,
   input  logic         comp_valid,
   output logic         comp_req,
   output logic [N-1:0] dac_code,
   output logic         sample_en,
   output logic         busy,
   output logic [N-1:0] dout,
   output logic         eoc,
   output logic         err
);

   localparam int KW = (N > 1) ? $clog2(N) : 1;
   localparam int SW = (SAMPLE_CYCLES > 1) ? $clog2(SAMPLE_CYCLES + 1) : 1;
   localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

   localparam logic [KW-1:0] BIT_MSB   = KW'(N - 1);
   localparam logic [SW-1:0] SMP_LOAD  = SW'(SAMPLE_CYCLES - 1);
   localparam logic [TW-1:0] WAIT_LOAD = TW'(TIMEOUT - 1);
   localparam logic [N-1:0]  SAR_MSB   = {1'b1, {(N-1){1'b0}}};

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_SAMPLE = 3'd1,
      S_REQ    = 3'd2,
      S_WAIT   = 3'd3,
      S_DONE   = 3'd4
   } state_t;

   state_t          state_q,    state_d;
   logic [KW-1:0]   bit_idx_q,  bit_idx_d;
   logic [N-1:0]    sar_q,      sar_d;
   logic [SW-1:0]   smp_cnt_q,  smp_cnt_d;
   logic [TW-1:0]   wait_cnt_q, wait_cnt_d;
   logic [N-1:0]    dout_q,     dout_d;
   logic            err_q,      err_d;

   logic [KW-1:0]   bit_nxt;
   logic            wait_tc;
   logic            resolve;
   logic            timed_out;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= S_IDLE;
         bit_idx_q  <= BIT_MSB;
         sar_q      <= '0;
         smp_cnt_q  <= '0;
         wait_cnt_q <= '0;
         dout_q     <= '0;
         err_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         bit_idx_q  <= bit_idx_d;
         sar_q      <= sar_d;
         smp_cnt_q  <= smp_cnt_d;
         wait_cnt_q <= wait_cnt_d;
         dout_q     <= dout_d;
         err_q      <= err_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      bit_idx_d  = bit_idx_q;
      sar_d      = sar_q;
      smp_cnt_d  = smp_cnt_q;
      wait_cnt_d = wait_cnt_q;
      dout_d     = dout_q;
      err_d      = err_q;

      comp_req   = 1'b0;
      sample_en  = 1'b0;
      busy       = 1'b1;
      eoc        = 1'b0;
      dac_code   = sar_q;

      bit_nxt    = bit_idx_q - 1'b1;
      wait_tc    = (wait_cnt_q == '0);
      // A missing comparator answer resolves the bit as if comp_result were 0.
      resolve    = comp_valid || wait_tc;
      timed_out  = !comp_valid && wait_tc;

      unique case (state_q)
         S_IDLE: begin
            busy     = 1'b0;
            dac_code = '0;
            if (start) begin
               state_d   = S_SAMPLE;
               err_d     = 1'b0;
               sar_d     = '0;
               bit_idx_d = BIT_MSB;
               smp_cnt_d = SMP_LOAD;
            end
         end

         S_SAMPLE: begin
            sample_en = 1'b1;
            bit_idx_d = BIT_MSB;
            sar_d     = SAR_MSB;
            if (smp_cnt_q == '0) begin
               state_d = S_REQ;
            end else begin
               smp_cnt_d = smp_cnt_q - 1'b1;
            end
         end

         S_REQ: begin
            // comp_valid is deliberately not looked at here: an answer on the
            // same edge as the request cannot belong to this trial.
            comp_req   = 1'b1;
            wait_cnt_d = WAIT_LOAD;
            state_d    = S_WAIT;
         end

         S_WAIT: begin
            if (resolve) begin
               if (timed_out || !comp_result) begin
                  sar_d[bit_idx_q] = 1'b0;
               end
               if (timed_out) begin
                  err_d = 1'b1;
               end
               if (bit_idx_q == '0) begin
                  // Load dout on entry to DONE so it is already valid while
                  // eoc is high.
                  dout_d  = sar_d;
                  state_d = S_DONE;
               end else begin
                  bit_idx_d      = bit_nxt;
                  sar_d[bit_nxt] = 1'b1;
                  state_d        = S_REQ;
               end
            end else begin
               wait_cnt_d = wait_cnt_q - 1'b1;
            end
         end

         S_DONE: begin
            eoc     = 1'b1;
            state_d = S_IDLE;
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase

      // Abort outranks comparator answers and timeouts; result and error
      // flag of the previous conversion are left untouched.
      if (abort && (state_q != S_IDLE)) begin
         state_d   = S_IDLE;
         bit_idx_d = BIT_MSB;
         sar_d     = '0;
         dout_d    = dout_q;
         err_d     = err_q;
      end
   end

   assign dout = dout_q;
   assign err  = err_q;

endmodule

// File: doc/sar_ctrl_10b.md
Name: sar_ctrl_10b

Overview:
- Successive-approximation controller for the 10-bit ADC.
- Sequences the 10-bit comparator: runs the sample phase, then resolves one bit per comparison, MSB first.
- Drives the trial code onto the comparator's reference input and returns the final code with an end-of-conversion pulse.
- Sits between the top-level ADC FSM (start/dout/eoc) and the comparator/DAC datapath.

Parameters:
- N, 10, resolution in bits; sets the width of dac_code and dout.
- SAMPLE_CYCLES, 4, number of cycles sample_en is held high (≥1).
- TIMEOUT, 8, maximum cycles to wait for comp_valid after comp_req (≥2).

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- start  in  1  conversion request; sampled only in IDLE.
- abort  in  1  synchronous abort; returns to IDLE with no eoc.
- comp_result  in  1  comparator decision; 1 = vip ≥ vin, so keep the trial bit.
- comp_valid  in  1  comp_result is valid this cycle.
- comp_req  out  1  one-cycle pulse that launches a comparison.
- dac_code  out  N  trial code to the comparator's vin side.
- sample_en  out  1  track/sample phase active.
- busy  out  1  high in every state except IDLE.
- dout  out  N  last completed conversion result.
- eoc  out  1  one-cycle pulse when dout updates.
- err  out  1  sticky timeout flag for the most recent conversion.

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE; all outputs 0; internal bit index = N-1; SAR register = 0.
- States: IDLE, SAMPLE, REQ, WAIT, DONE.
- IDLE:
  - busy=0, dac_code=0.
  - start=1 → SAMPLE; clear err, SAR register and sample counter.
- SAMPLE:
  - sample_en=1 for exactly SAMPLE_CYCLES cycles, then → REQ.
  - Bit index = N-1; SAR register = 1<<(N-1).
- REQ:
  - comp_req=1 for one cycle; dac_code = SAR register (current bit k set); clear the wait counter; → WAIT.
- WAIT:
  - dac_code held stable.
  - comp_valid=1: if comp_result=0, clear bit k. Then if k==0 → DONE; else k ← k-1, set bit k-1, → REQ.
  - comp_valid is ignored in REQ. A comp_valid on the same edge as comp_req is not accepted.
  - Timeout: wait counter reaches TIMEOUT with no comp_valid → treat as comp_result=0, set err=1, advance as above.
- DONE:
  - dout ← SAR register; eoc=1 for this cycle only; → IDLE.
  - dac_code returns to 0 in IDLE.
- start while busy is ignored; there is no queueing.
- start held high through DONE begins a new conversion from IDLE on the following cycle.
- abort=1 in any non-IDLE state → IDLE next cycle:
  - no eoc; dout and err unchanged; comp_req and sample_en deasserted.
  - abort has priority over comp_valid and timeout in the same cycle.
- Latency with comp_valid arriving one cycle after comp_req:
  - start sampled at edge 0.
  - eoc high in cycle SAMPLE_CYCLES + 2N + 1, i.e. cycle 25 at the defaults.
- dout holds its value until the next eoc; it is never cleared except by rst.
- Reset mid-conversion: immediate return to reset values; no eoc.
- Arithmetic: only bit set/clear on the N-bit SAR register; no carries and no wrap.

Test Plan:
- Ideal comparator model (comp_valid one cycle after comp_req, comp_result = vip ≥ dac_code), vip=0x2A5, start pulse → trial sequence 0x200, 0x300, 0x280, 0x2C0, 0x2A0, …; dout=0x2A5, eoc single pulse in cycle 25, err=0.
- vip=0x3FF, then vip=0x000 → dout=0x3FF, then 0x000; every trial code in the 0x000 run is a single set bit.
- Comparator never asserts comp_valid → each bit times out after 8 cycles; dout=0x000, err=1, eoc still pulses.
- start re-pulsed during SAMPLE and WAIT → ignored; exactly one eoc per accepted start.
- abort asserted in the 5th REQ → IDLE next cycle, no eoc, dout keeps its prior 0x2A5.
- rst=0 during WAIT → all outputs 0 asynchronously.
- Following start with vip=0x155 → dout=0x155.
